// File: rtl/tcm_mem_ram_dp.sv
// Dual-port byte-enable TCM RAM. Both ports share one clock. A sequencer clears every word after reset.
// Collision mode, output register and clear-after-reset are set by parameters.
//
// state    | meaning
// ST_RESET | held in reset; the first edge after release leaves this state
// ST_INIT  | writes zero to word[cnt] once per cycle; busy_o is high
// ST_READY | accepts accesses on both ports until the next reset
module tcm_mem_ram_dp #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 6144,
  parameter int ADDR_W      = 13,
  parameter int WRITE_FIRST = 0,
  parameter int OUT_REG     = 0,
  parameter int INIT_EN     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en0_i,
  input  logic [ADDR_W-1:0]     addr0_i,
  input  logic [DATA_W-1:0]     data0_i,
  input  logic [DATA_W/8-1:0]   wr0_i,
  output logic [DATA_W-1:0]     data0_o,
  output logic                  valid0_o,
  input  logic                  en1_i,
  input  logic [ADDR_W-1:0]     addr1_i,
  input  logic [DATA_W-1:0]     data1_i,
  input  logic [DATA_W/8-1:0]   wr1_i,
  output logic [DATA_W-1:0]     data1_o,
  output logic                  valid1_o,
  output logic                  busy_o
);

  localparam int BYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic                busy_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                acc0, acc1, inr0, inr1;
  logic [BYTES-1:0]    wen0, wen1;
  logic [DATA_W-1:0]   rd0, rd1;
  logic [DATA_W-1:0]   s1_data0, s1_data1;
  logic                s1_valid0, s1_valid1;

  assign acc0 = en0_i && (state == ST_READY);
  assign acc1 = en1_i && (state == ST_READY);
  assign inr0 = (32'(addr0_i) < 32'(DEPTH));
  assign inr1 = (32'(addr1_i) < 32'(DEPTH));
  assign wen0 = {BYTES{acc0 && inr0}} & wr0_i;
  assign wen1 = {BYTES{acc1 && inr1}} & wr1_i;
  assign busy_o = busy_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_RESET;
      cnt    <= '0;
      busy_q <= (INIT_EN != 0);
    end else begin
      case (state)
        ST_RESET: begin
          cnt <= '0;
          if (INIT_EN != 0) state <= ST_INIT;
          else              state <= ST_READY;
        end
        ST_INIT: begin
          if (cnt == LAST) begin
            state  <= ST_READY;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_READY;
      endcase
    end
  end

  // Port 0 is applied last so that it wins any byte both ports write.
  always_ff @(posedge clk_i) begin
    if (state == ST_INIT) mem[cnt] <= '0;
    for (int b = 0; b < BYTES; b++)
      if (wen1[b]) mem[addr1_i][8*b +: 8] <= data1_i[8*b +: 8];
    for (int b = 0; b < BYTES; b++)
      if (wen0[b]) mem[addr0_i][8*b +: 8] <= data0_i[8*b +: 8];
  end

  always_comb begin
    rd0 = '0;
    rd1 = '0;
    if (inr0) rd0 = mem[addr0_i];
    if (inr1) rd1 = mem[addr1_i];
    if (WRITE_FIRST != 0) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wen1[b] && (addr1_i == addr0_i)) rd0[8*b +: 8] = data1_i[8*b +: 8];
        if (wen0[b])                         rd0[8*b +: 8] = data0_i[8*b +: 8];
        if (wen1[b])                         rd1[8*b +: 8] = data1_i[8*b +: 8];
        if (wen0[b] && (addr0_i == addr1_i)) rd1[8*b +: 8] = data0_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_data0  <= '0;
      s1_data1  <= '0;
      s1_valid0 <= 1'b0;
      s1_valid1 <= 1'b0;
    end else begin
      s1_valid0 <= acc0;
      s1_valid1 <= acc1;
      if (acc0) s1_data0 <= rd0;
      if (acc1) s1_data1 <= rd1;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] s2_data0, s2_data1;
    logic              s2_valid0, s2_valid1;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        s2_data0  <= '0;
        s2_data1  <= '0;
        s2_valid0 <= 1'b0;
        s2_valid1 <= 1'b0;
      end else begin
        s2_valid0 <= s1_valid0;
        s2_valid1 <= s1_valid1;
        if (s1_valid0) s2_data0 <= s1_data0;
        if (s1_valid1) s2_data1 <= s1_data1;
      end
    end

    assign data0_o  = s2_data0;
    assign data1_o  = s2_data1;
    assign valid0_o = s2_valid0;
    assign valid1_o = s2_valid1;
  end else begin : g_noreg
    assign data0_o  = s1_data0;
    assign data1_o  = s1_data1;
    assign valid0_o = s1_valid0;
    assign valid1_o = s1_valid1;
  end

endmodule
